// File: rtl/calc_core_pkg.sv
// Shared types and constants for calc_core: FSM states, step count, result length.
// Optional saturation (macro CALC_CORE_SAT_EN) narrows the result to 32 bits.
package calc_core_pkg;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIX, S_SEND} calc_state_t;

   localparam int MUL_STEPS = 32;

`ifdef CALC_CORE_SAT_EN
   localparam int NBYTES = 4;
`else
   localparam int NBYTES = 8;
`endif

   localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
   localparam logic [31:0] SAT_MIN = 32'h8000_0000;

`ifdef CALC_CORE_SAT_EN
   // Clamp a signed 64-bit value into the signed 32-bit range.
   function automatic logic [31:0] sat32(input logic [63:0] v);
      if ($signed(v) > $signed({32'h0, SAT_MAX}))
         return SAT_MAX;
      if ($signed(v) < $signed({32'hFFFF_FFFF, SAT_MIN}))
         return SAT_MIN;
      return v[31:0];
   endfunction
`endif

endpackage

// File: rtl/shift_add_mul.sv
// Sequential unsigned W x W -> 2W shift-add multiplier, one partial product per enabled cycle.
// start loads operands; done is high during the cycle whose edge performs the last step.
module shift_add_mul
   import calc_core_pkg::*;
#(
   parameter int W = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           ena,
   input  logic [W-1:0]   mcand,
   input  logic [W-1:0]   mplier,
   output logic [2*W-1:0] product,
   output logic           done
);

   logic [2*W-1:0] acc_q;
   logic [2*W-1:0] mcand_q;
   logic [W-1:0]   mplier_q;
   logic [5:0]     cnt_q;
   logic           run_q;

   assign product = acc_q;
   assign done    = run_q && (cnt_q == 6'(MUL_STEPS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
      end else if (ena) begin
         if (start) begin
            acc_q    <= '0;
            mcand_q  <= {{W{1'b0}}, mcand};
            mplier_q <= mplier;
            cnt_q    <= '0;
            run_q    <= 1'b1;
         end else if (run_q) begin
            if (mplier_q[0])
               acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 6'd1;
            if (done)
               run_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/calc_core.sv
// Signed multiply of a0*a1 via shift-add, result streamed MSB-first as bytes over valid/ready.
// Macro CALC_CORE_SAT_EN: saturate to signed 32 bits and send 4 bytes instead of 8.
module calc_core
   import calc_core_pkg::*;
#(
   parameter int MUL_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [MUL_W-1:0] a0,
   input  logic [MUL_W-1:0] a1,
   input  logic             start_calc,
   output logic             core_busy,
   output logic [7:0]       out_byte,
   output logic             out_valid,
   output logic             out_last,
   input  logic             out_ready
);

   localparam int RW = 8 * NBYTES;
   localparam int IW = $clog2(NBYTES);

   calc_state_t      state_q;
   logic             start_q;
   logic             sign_q;
   logic [RW-1:0]    res_q;
   logic [IW-1:0]    idx_q;
   logic             busy_q;
   logic [7:0]       byte_q;
   logic             valid_q;
   logic             last_q;

   logic             req;
   logic             mul_start;
   logic             mul_done;
   logic [MUL_W-1:0] abs0, abs1;
   logic [2*MUL_W-1:0] prod, signed_prod;
   logic [RW-1:0]    res_fix;
   logic             hs;

   assign req       = start_calc & ~start_q;
   assign mul_start = (state_q == S_IDLE) & req;
   assign abs0      = a0[MUL_W-1] ? -a0 : a0;
   assign abs1      = a1[MUL_W-1] ? -a1 : a1;
   assign hs        = valid_q & out_ready;

   shift_add_mul #(.W(MUL_W)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .ena     (ena),
      .mcand   (abs0),
      .mplier  (abs1),
      .product (prod),
      .done    (mul_done)
   );

   assign signed_prod = sign_q ? -prod : prod;
`ifdef CALC_CORE_SAT_EN
   assign res_fix = RW'(sat32(signed_prod));
`else
   assign res_fix = RW'(signed_prod);
`endif

   assign core_busy = busy_q;
   assign out_byte  = byte_q;
   assign out_valid = valid_q;
   assign out_last  = last_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         start_q <= 1'b0;
         sign_q  <= 1'b0;
         res_q   <= '0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         byte_q  <= 8'h00;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else if (ena) begin
         start_q <= start_calc;
         case (state_q)
            S_IDLE: begin
               if (req) begin
                  sign_q  <= a0[MUL_W-1] ^ a1[MUL_W-1];
                  busy_q  <= 1'b1;
                  state_q <= S_MUL;
               end
            end
            S_MUL: begin
               if (mul_done)
                  state_q <= S_FIX;
            end
            S_FIX: begin
               // The output byte register holds the MSB; res_q keeps the rest left-aligned.
               byte_q  <= res_fix[RW-1 -: 8];
               res_q   <= res_fix << 8;
               idx_q   <= '0;
               valid_q <= 1'b1;
               last_q  <= 1'b0;
               state_q <= S_SEND;
            end
            S_SEND: begin
               if (hs) begin
                  if (last_q) begin
                     busy_q  <= 1'b0;
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     byte_q  <= 8'h00;
                     state_q <= S_IDLE;
                  end else begin
                     byte_q <= res_q[RW-1 -: 8];
                     res_q  <= res_q << 8;
                     idx_q  <= idx_q + 1'b1;
                     last_q <= (idx_q == IW'(NBYTES - 2));
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_core.sv
// Self-checking bench for calc_core: vector table plus handshake, enable, retrigger and reset sequences.
module tb_calc_core;
   import calc_core_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ena;
   logic [31:0] a0, a1;
   logic        start_calc;
   logic        core_busy;
   logic [7:0]  out_byte;
   logic        out_valid;
   logic        out_last;
   logic        out_ready;

   calc_core #(.MUL_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .a0         (a0),
      .a1         (a1),
      .start_calc (start_calc),
      .core_busy  (core_busy),
      .out_byte   (out_byte),
      .out_valid  (out_valid),
      .out_last   (out_last),
      .out_ready  (out_ready)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   logic [8:0] sbq[$];

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] p;
   } vec_t;
   vec_t vecs[11];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] expected_word(input logic [63:0] p);
`ifdef CALC_CORE_SAT_EN
      if ($signed(p) > 64'sh0000_0000_7FFF_FFFF) return 64'h7FFF_FFFF;
      if ($signed(p) < -64'sh0000_0000_8000_0000) return 64'h8000_0000;
      return {32'h0, p[31:0]};
`else
      return p;
`endif
   endfunction

   task automatic push_exp(input logic [63:0] p);
      logic [63:0] w, sh;
      w = expected_word(p);
      for (int i = 0; i < NBYTES; i++) begin
         sh = w >> (8 * (NBYTES - 1 - i));
         sbq.push_back({(i == NBYTES - 1), sh[7:0]});
      end
   endtask

   function automatic logic rdy(input int k);
      return (k % 4 == 0) || (k % 4 == 3);
   endfunction

   // rmode 0: out_ready held high; rmode 1: ready follows 1-0-0-1 while bytes are offered.
   task automatic run_job(input logic [31:0] x, input logic [31:0] y, input logic [63:0] p,
                          input int rmode, input int ena_at, input bit retrig, input int exp_first);
      int cyc, first, rc;
      bit fin, bad;
      logic [8:0] e;
      @(posedge clk); #1;
      push_exp(p);
      a0 = x; a1 = y; start_calc = 1'b1; ena = 1'b1;
      out_ready = (rmode == 0) ? 1'b1 : rdy(0);
      @(posedge clk); #1;
      cyc = 0; first = 0; rc = 0; fin = 1'b0;
      while (!fin && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) chk("busy_after_req", {63'h0, core_busy}, 64'h1);
         if (out_valid) begin
            if (first == 0) begin
               first = cyc;
               chk("first_valid_cycle", 64'(cyc), 64'(exp_first));
            end
            if (sbq.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL extra_byte: got %h, expected no byte", out_byte);
               fin = 1'b1;
            end else begin
               e = sbq[0];
               chk("byte", {55'h0, out_last, out_byte}, {55'h0, e});
               if (out_ready) begin
                  void'(sbq.pop_front());
                  if (e[8]) fin = 1'b1;
               end
            end
            rc++;
         end
         @(posedge clk); #1;
         start_calc = retrig && (first != 0) && (cyc > first);
         ena = !(ena_at > 0 && cyc >= ena_at && cyc < ena_at + 5);
         out_ready = (rmode == 0) ? 1'b1 : rdy(rc);
      end
      if (!fin) begin
         n_vec++; n_err++;
         $display("FAIL job_timeout: got %0d cycles, expected completion", cyc);
         sbq.delete();
      end
      @(negedge clk);
      chk("idle_after_last", {61'h0, core_busy, out_valid, out_last}, 64'h0);
      if (retrig) begin
         bad = 1'b0;
         repeat (40) begin
            @(negedge clk);
            if (core_busy || out_valid) bad = 1'b1;
         end
         chk("no_retrigger", {63'h0, bad}, 64'h0);
         @(posedge clk); #1;
         start_calc = 1'b0;
      end
   endtask

   initial begin
      logic signed [63:0] sx, sy;
      int w;
      rst_n = 1'b0; ena = 1'b1; a0 = '0; a1 = '0; start_calc = 1'b0; out_ready = 1'b1;

      vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F};
      vecs[1] = '{32'hFFFF_FFFE,  32'd3,          64'hFFFF_FFFF_FFFF_FFFA};
      vecs[2] = '{32'h7FFF_FFFF,  32'd2,          64'h0000_0000_FFFF_FFFE};
      vecs[3] = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
      vecs[4] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001};
      vecs[5] = '{32'h8000_0000,  32'h7FFF_FFFF,  64'hC000_0000_8000_0000};
      vecs[6] = '{32'h0,          32'h1234_5678,  64'h0};
      vecs[7] = '{32'h1234_5678,  32'hFFFF_FFFF,  64'hFFFF_FFFF_EDCB_A988};
      for (int i = 8; i < 11; i++) begin
         vecs[i].a = $urandom;
         vecs[i].b = $urandom;
         sx = {{32{vecs[i].a[31]}}, vecs[i].a};
         sy = {{32{vecs[i].b[31]}}, vecs[i].b};
         vecs[i].p = sx * sy;
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_state", {52'h0, core_busy, out_valid, out_last, out_byte}, 64'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++)
         run_job(vecs[i].a, vecs[i].b, vecs[i].p, 0, 0, 1'b0, 34);

      // Ready toggling per byte, with a 5-cycle enable drop in the middle of the multiply.
      run_job(32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 1, 10, 1'b0, 39);

      // Rising start during the send phase, then held high after completion.
      run_job(32'h7FFF_FFFF, 32'd2, 64'h0000_0000_FFFF_FFFE, 0, 0, 1'b1, 34);

      // Reset pulse while a result is being offered.
      @(posedge clk); #1;
      a0 = 32'd3; a1 = 32'd5; start_calc = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      start_calc = 1'b0;
      w = 0;
      while (!out_valid && w < 60) begin
         @(negedge clk);
         w++;
      end
      chk("valid_before_reset", {63'h0, out_valid}, 64'h1);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_outputs", {52'h0, core_busy, out_valid, out_last, out_byte}, 64'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      run_job(32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 0, 0, 1'b0, 34);

      chk("scoreboard_empty", 64'(sbq.size()), 64'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/calc_core.md
# calc_core

Arithmetic core downstream of the parameter loader: takes the two signed 32-bit operands `a0`/`a1` when `start_calc` rises and computes the signed product with a sequential shift-add multiplier. It then streams the result MSB-first as bytes over a valid/ready handshake towards the output pins. `core_busy` is held high for the whole job so the loader does not present new parameters until the result has been fully drained.

## Interface
- `MUL_W`, 32, operand width; the product is 2*MUL_W bits.
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `ena`  in  1  global enable; when low, all state is frozen
- `a0`  in  32  signed operand A, sampled on start
- `a1`  in  32  signed operand B, sampled on start
- `start_calc`  in  1  level from the loader; its rising edge requests a job
- `core_busy`  out  1  high from job acceptance until the last byte is accepted
- `out_byte`  out  8  current result byte
- `out_valid`  out  1  `out_byte` is valid
- `out_last`  out  1  marks the final byte of the result
- `out_ready`  in  1  the consumer accepts the byte when `out_valid & out_ready`

## Operation
- Reset values: `core_busy`=0, `out_byte`=0x00, `out_valid`=0, `out_last`=0, state S_IDLE, start edge register=0.
- Start detect: `start_q` is the registered `start_calc`, updated only when `ena`=1. A request is `start_calc & ~start_q`.
- States and transitions:
  - S_IDLE: on a request, latch `|a0|`, `|a1|` and `sign = a0[31]^a1[31]`, clear the accumulator and set the counter to 0. Go to S_MUL.
  - S_MUL: one partial-product step per cycle (add the shifted multiplicand when the multiplier LSB is 1; shift right). After 32 steps go to S_FIX.
  - S_FIX: if `sign`, replace the 64-bit result with its two's complement. Set the byte index to 0 and go to S_SEND.
  - S_SEND: present the result byte selected by the index, MSB first. On each handshake, increment the index. On the handshake with `out_last`=1, go to S_IDLE.
- Magnitude arithmetic is unsigned 32x32→64. |−2^31| = 2^31 is representable, so the full signed range is exact.
- A request while not in S_IDLE is ignored. A request that is still high after the job finishes does not retrigger, because only a rising edge starts a job.
- `ena`=0: no state, counter, edge register or output changes, including during S_SEND. A handshake is not counted while `ena`=0.
- `rst_n` asserted mid-job: the job is aborted and all outputs return to their reset values asynchronously.

## Timing
- A request is sampled at edge T. `core_busy`=1 from T+1.
- S_MUL occupies T+1..T+32 and S_FIX T+33. The first `out_valid`=1 is at T+34.
- `out_valid` stays high and `out_byte` is stable until it is accepted. The next byte appears the cycle after the handshake, so the stream is gap-free when `out_ready` is held high.
- The last handshake occurs at edge L. From L+1: `core_busy`=0, `out_valid`=0, `out_last`=0.
- Minimum job length, with `out_ready`=1: 34 + NBYTES cycles.

## Configuration
- `CALC_CORE_SAT_EN` defined: S_FIX also saturates the signed result to the 32-bit range [0x80000000, 0x7FFFFFFF]. NBYTES=4, and only the low word is sent, MSB first.
- `CALC_CORE_SAT_EN` not defined: the full 64-bit product is sent with NBYTES=8. No saturation logic is present.

## Structure
- `calc_core_pkg`:
  - `calc_state_t` enum {S_IDLE, S_MUL, S_FIX, S_SEND}
  - `MUL_STEPS`=32
  - `NBYTES` (8, or 4 under the macro)
  - saturation limits
- Sub-module `shift_add_mul`: sequential unsigned multiplier with ports `start`, `ena`, `mcand`, `mplier`, `product`, `done`. `calc_core` owns the sign handling, the FSM and the serializer.

## Test plan
- `a0`=3, `a1`=5, `out_ready`=1 → `core_busy` from T+1. Bytes 00 00 00 00 00 00 00 0F from T+34, with `out_last` on 0x0F; `core_busy`=0 one cycle later. Under the macro: 00 00 00 0F.
- `a0`=−2, `a1`=3 → bytes FF FF FF FF FF FF FF FA. Under the macro: FF FF FF FA.
- `a0`=0x7FFFFFFF, `a1`=2 → 00 00 00 00 FF FF FF FE. Under the macro, saturated: 7F FF FF FF.
- `out_ready` toggled 1-0-0-1 per byte → each byte is held while not ready, no byte is skipped or duplicated, and `ena` low for 5 cycles mid-S_MUL delays first `out_valid` by exactly 5 cycles.
- A second `start_calc` rising edge during S_SEND, and `start_calc` held high after completion → no new job; `core_busy` stays 0 after the last byte.
- `rst_n` pulsed low during S_SEND → all outputs 0 immediately; a new request after release produces a correct, complete result.
